warmboot_sequencer: RTL
=======================

Name: warmboot_sequencer

Overview:
Fabric-side controller that shares the single WARMBOOT_wrapper (SLOT/BOOT) resource between NUM_REQ user-logic requesters. Arbitrates reconfiguration requests round-robin and notifies the CPU through one CPU_IRQ_wrapper IRQ line. It then waits for a CPU ack, veto or timeout, holds SLOT stable for a setup window, pulses BOOT, and locks until reset. Its RESET input is driven from WARMBOOT_wrapper.RESET.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
SLOT_W, 4, width of slot index (matches WARMBOOT_wrapper.SLOT)
SETUP_CYCLES, 4, cycles SLOT is held stable before BOOT rises (>=1)
BOOT_CYCLES, 2, width of BOOT pulse in cycles (>=1)
ACK_TIMEOUT, 255, max NOTIFY cycles awaiting CPU ack; 0 = skip NOTIFY entirely

Ports:
clk  in  1  fabric clock
RESET  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester boot request; held until req_ready
req_slot  in  NUM_REQ*SLOT_W  requested slot, requester i at bits [i*SLOT_W +: SLOT_W]
req_ready  out  NUM_REQ  one-cycle grant pulse to winning requester
cpu_ack  in  1  CPU approves pending boot (level, sampled in NOTIFY)
cpu_veto  in  1  CPU rejects pending boot (level, sampled in NOTIFY)
irq  out  1  to CPU_IRQ_wrapper IRQ bit; high throughout NOTIFY
slot  out  SLOT_W  to WARMBOOT_wrapper.SLOT
boot  out  1  to WARMBOOT_wrapper.BOOT
busy  out  1  high in any state except IDLE
granted_id  out  $clog2(NUM_REQ) (min 1)  id of last granted requester
timed_out  out  1  sticky: current boot proceeded without ack
vetoed  out  1  one-cycle pulse on veto

Behaviour:
- Clock and reset: all state on posedge clk; all flops are cleared asynchronously by RESET.
- Reset values: req_ready=0, irq=0, slot=0, boot=0, busy=0, granted_id=0, timed_out=0, vetoed=0, rr pointer=0, state=IDLE.
- Registered outputs: all outputs are registered; no combinational input-to-output path.
- FSM states: IDLE, NOTIFY, SETUP, BOOT, LOCKED.
- IDLE: on an edge with any req_valid, the arbiter picks the first set bit searching from the rr pointer upward with wrap.
  - Latch req_slot of the winner and set granted_id.
  - Pulse req_ready[winner] for the following cycle only.
  - Set rr pointer = (winner+1) mod NUM_REQ.
  - Next state is NOTIFY, or SETUP if ACK_TIMEOUT=0.
- NOTIFY:
  - irq=1; a cycle counter starts at 0.
  - cpu_veto → IDLE, vetoed pulses for one cycle, irq drops. Veto wins over ack in the same cycle.
  - cpu_ack → SETUP.
  - If counter==ACK_TIMEOUT-1 with neither ack nor veto → SETUP and timed_out=1. NOTIFY therefore lasts at most ACK_TIMEOUT cycles.
  - An ack on the final cycle is a normal ack (timed_out=0).
- SETUP: slot = latched slot, boot=0 for exactly SETUP_CYCLES cycles, then → BOOT.
- BOOT: boot=1 for exactly BOOT_CYCLES cycles with slot unchanged, then → LOCKED.
- LOCKED:
  - boot=0, slot held, busy=1.
  - New requests are ignored and req_ready stays 0; requests are not queued.
  - Exit is only via RESET, since fabric reconfiguration is expected.
- slot output: 0 in IDLE and NOTIFY; latched value from SETUP through LOCKED.
- Grant data: a requester dropping req_valid after the grant has no effect; the slot was captured at the grant edge.
- Counter width: one shared counter of $clog2(max(ACK_TIMEOUT,SETUP_CYCLES,BOOT_CYCLES)+1) bits, cleared on each state entry. No wrap-around is reachable.
- Reset mid-operation: boot deasserts immediately (asynchronously), and the rr pointer returns to 0.

Decomposition:
- warmboot_pkg:
  - state enum (IDLE/NOTIFY/SETUP/BOOT/LOCKED)
  - localparam counter-width helper
  - IRQ bit index constant WARMBOOT_IRQ_BIT=0
- Sub-module rr_arbiter: parameter N; ports req[N], ptr, and outputs gnt_onehot[N], gnt_id, any. Purely combinational priority-from-pointer search. The pointer register lives in warmboot_sequencer.

Test Plan:
1. Basic ack: req_valid[2]=1, slot 5, ack asserted on 3rd NOTIFY cycle (defaults) → req_ready[2] pulse, irq high 3 cycles, slot=5 for 4 cycles with boot=0, boot=1 for 2 cycles, then LOCKED with busy=1 and granted_id=2.
2. Round-robin after veto: req_valid=4'b0011 with slots 1/9, veto first NOTIFY → grant 0, vetoed pulse, back to IDLE; next grant 1, ack → slot=9 booted.
3. Timeout: ACK_TIMEOUT=8, no ack/veto → irq high exactly 8 cycles, then SETUP with timed_out=1 and slot driven.
4. Simultaneous ack+veto in NOTIFY → treated as veto: IDLE, boot never asserted, timed_out=0.
5. RESET asserted mid-BOOT → boot, slot and busy fall before the next clock edge; after release, req_valid=4'b1000 is granted id 3 from pointer 0.
6. ACK_TIMEOUT=0: request → irq never asserts, SETUP entered the cycle after the grant; requests during LOCKED get no req_ready.

Source files
------------

// File: rtl/warmboot_pkg.sv
// Shared types and sizing helpers for the warm-boot sequencer and its arbiter.
package warmboot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NOTIFY,
    SETUP,
    BOOT,
    LOCKED
  } wb_state_e;

  localparam int WARMBOOT_IRQ_BIT = 0;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One counter serves NOTIFY, SETUP and BOOT, so it must hold the largest limit.
  function automatic int cnt_width(input int ack_timeout, input int setup_cycles,
                                   input int boot_cycles);
    int m;
    m = ack_timeout;
    if (setup_cycles > m) m = setup_cycles;
    if (boot_cycles > m) m = boot_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/warmboot_sequencer_if.sv
// Requester, CPU and WARMBOOT_wrapper signals of the warm-boot sequencer.
interface warmboot_sequencer_if #(
  parameter int NUM_REQ = 4,
  parameter int SLOT_W  = 4
);
  import warmboot_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*SLOT_W-1:0] req_slot;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cpu_ack;
  logic                      cpu_veto;
  logic                      irq;
  logic [SLOT_W-1:0]         slot;
  logic                      boot;
  logic                      busy;
  logic [ID_W-1:0]           granted_id;
  logic                      timed_out;
  logic                      vetoed;

  modport master (
    output req_valid, req_slot, cpu_ack, cpu_veto,
    input  req_ready, irq, slot, boot, busy, granted_id, timed_out, vetoed
  );

  modport slave (
    input  req_valid, req_slot, cpu_ack, cpu_veto,
    output req_ready, irq, slot, boot, busy, granted_id, timed_out, vetoed
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter
  import warmboot_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  always_comb begin
    int idx;
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_id          = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/warmboot_sequencer.sv
// Shares the WARMBOOT_wrapper SLOT/BOOT resource between requesters: arbitrate,
// ask the CPU, hold SLOT for a setup window, pulse BOOT, then lock until RESET.
module warmboot_sequencer
  import warmboot_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SLOT_W       = 4,
  parameter int SETUP_CYCLES = 4,
  parameter int BOOT_CYCLES  = 2,
  parameter int ACK_TIMEOUT  = 255
) (
  input logic           clk,
  input logic           RESET,
  warmboot_sequencer_if.slave bus
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(ACK_TIMEOUT, SETUP_CYCLES, BOOT_CYCLES);

  localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);

  wb_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    rr_ptr;
  logic [SLOT_W-1:0]  slot_q;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic [SLOT_W-1:0]  win_slot;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .gnt_onehot(arb_onehot),
    .gnt_id    (arb_id),
    .any       (arb_any)
  );

  assign win_slot = bus.req_slot[int'(arb_id)*SLOT_W +: SLOT_W];

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state          <= IDLE;
      cnt            <= '0;
      rr_ptr         <= '0;
      slot_q         <= '0;
      bus.req_ready  <= '0;
      bus.irq        <= 1'b0;
      bus.slot       <= '0;
      bus.boot       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.granted_id <= '0;
      bus.timed_out  <= 1'b0;
      bus.vetoed     <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      bus.vetoed    <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            slot_q         <= win_slot;
            bus.granted_id <= arb_id;
            bus.req_ready  <= arb_onehot;
            rr_ptr         <= (arb_id == LAST_ID) ? '0 : arb_id + 1'b1;
            bus.timed_out  <= 1'b0;
            bus.busy       <= 1'b1;
            cnt            <= '0;
            if (ACK_TIMEOUT == 0) begin
              state    <= SETUP;
              bus.slot <= win_slot;
            end else begin
              state   <= NOTIFY;
              bus.irq <= 1'b1;
            end
          end
        end
        // Veto outranks ack, and an ack on the last cycle still counts as an ack.
        NOTIFY: begin
          if (bus.cpu_veto) begin
            state      <= IDLE;
            bus.irq    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.vetoed <= 1'b1;
          end else if (bus.cpu_ack || cnt == ACK_LAST) begin
            state         <= SETUP;
            bus.irq       <= 1'b0;
            bus.slot      <= slot_q;
            bus.timed_out <= !bus.cpu_ack;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state    <= BOOT;
            bus.boot <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BOOT: begin
          if (cnt == BOOT_LAST) begin
            state    <= LOCKED;
            bus.boot <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Fabric is about to be reconfigured; only RESET leaves this state.
        LOCKED: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
